// File: rtl/data_sram_slave.sv
// data_sram_slave
//   Responder end of the data-side SRAM-like interface, sitting between the
//   CPU data port and an on-chip synchronous block RAM. Requests are accepted
//   with data_sram_addr_ok, the RAM is accessed in the accepting cycle, and
//   completions come back in acceptance order on data_sram_data_ok /
//   data_sram_rdata after LATENCY extra cycles.
//
//   Handshake semantics: a request transfers in any cycle where
//   data_sram_req && data_sram_addr_ok. addr_ok is computed from registered
//   state only (never from req). data_sram_data_ok is a one-cycle pulse with
//   no backpressure: the master must take it.
//
// Parameters
//   ADDR_W   RAM word-address width (RAM holds 2^ADDR_W 32-bit words)
//   LATENCY  extra response delay in cycles, 0..7
//   DEPTH    maximum outstanding requests, 1..4
//
// Ports
//   clk, resetn               clock, asynchronous active-low reset
//   data_sram_req/wr/size     request valid, write flag, size (informational)
//   data_sram_wstrb/addr      byte enables, byte address
//   data_sram_wdata           write data
//   data_sram_addr_ok         request accepted this cycle
//   data_sram_data_ok/rdata   completion pulse and read data (0 otherwise)
//   ram_en/we/addr/wdata      RAM access strobe, byte enables, word addr, data
//   ram_rdata                 RAM read data, valid the cycle after ram_en
module data_sram_slave #(
    parameter int ADDR_W  = 14,
    parameter int LATENCY = 0,
    parameter int DEPTH   = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              data_sram_req,
    input  logic              data_sram_wr,
    input  logic [1:0]        data_sram_size,
    input  logic [3:0]        data_sram_wstrb,
    input  logic [31:0]       data_sram_addr,
    input  logic [31:0]       data_sram_wdata,
    output logic              data_sram_addr_ok,
    output logic              data_sram_data_ok,
    output logic [31:0]       data_sram_rdata,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam logic [2:0] LAT_INIT = 3'(LATENCY);
    localparam logic [2:0] DEPTH_C  = 3'(DEPTH);
    localparam logic [1:0] LAST_IDX = 2'(DEPTH - 1);

    // Queue storage is sized for the largest legal DEPTH; only the first
    // DEPTH slots are ever addressed because the pointers wrap at DEPTH.
    logic        is_wr_q [4];
    logic [2:0]  cd_q    [4];
    logic [31:0] dat_q   [4];
    logic        vld_q   [4];

    logic [2:0]  count;
    logic [1:0]  head;
    logic [1:0]  tail;

    // A read pushed last cycle has its data on ram_rdata right now.
    logic        cap_pending;
    logic [1:0]  cap_idx;

    logic        hs;
    logic        head_live;
    logic        retire;

    // Size and the ignored address bits carry no behaviour.
    logic        unused_bits;
    assign unused_bits = ^{data_sram_size, data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

    function automatic logic [1:0] next_idx(input logic [1:0] p);
        return (p == LAST_IDX) ? 2'd0 : p + 2'd1;
    endfunction

    assign data_sram_addr_ok = resetn && (count < DEPTH_C);
    assign hs                = data_sram_req && data_sram_addr_ok;

    assign ram_en    = hs;
    assign ram_we    = (hs && data_sram_wr) ? data_sram_wstrb : 4'b0000;
    assign ram_addr  = hs ? data_sram_addr[ADDR_W+1:2] : '0;
    assign ram_wdata = hs ? data_sram_wdata : 32'd0;

    // The head may retire on the very cycle its read data arrives from the
    // RAM (LATENCY = 0), so the live RAM output counts as available data.
    assign head_live = cap_pending && (cap_idx == head);
    assign retire    = (count != 3'd0) && (cd_q[head] == 3'd0) && (vld_q[head] || head_live);

    assign data_sram_data_ok = retire;

    always_comb begin
        data_sram_rdata = 32'd0;
        if (retire && !is_wr_q[head]) begin
            data_sram_rdata = vld_q[head] ? dat_q[head] : ram_rdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count       <= 3'd0;
            head        <= 2'd0;
            tail        <= 2'd0;
            cap_pending <= 1'b0;
            cap_idx     <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                is_wr_q[i] <= 1'b0;
                cd_q[i]    <= 3'd0;
                dat_q[i]   <= 32'd0;
                vld_q[i]   <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (cd_q[i] != 3'd0) begin
                    cd_q[i] <= cd_q[i] - 3'd1;
                end
            end

            if (cap_pending) begin
                dat_q[cap_idx] <= ram_rdata;
                vld_q[cap_idx] <= 1'b1;
            end
            cap_pending <= hs && !data_sram_wr;
            cap_idx     <= tail;

            // Placed after the capture so a push into a slot being captured
            // on the same cycle (DEPTH = 1) takes precedence.
            if (hs) begin
                is_wr_q[tail] <= data_sram_wr;
                cd_q[tail]    <= LAT_INIT;
                dat_q[tail]   <= 32'd0;
                vld_q[tail]   <= data_sram_wr;
                tail          <= next_idx(tail);
            end

            if (retire) begin
                head <= next_idx(head);
            end

            case ({hs, retire})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

endmodule
